uart_rx_sampler: RTL
====================

# uart_rx_sampler

Oversampling UART receiver that sits directly upstream of the RX FIFO write path. It turns the asynchronous `rx` pin into validated 8-bit bytes, presented as a one-cycle `rx_valid` strobe with `rx_result`. It also detects glitched start bits and framing errors, so the controller never sees a corrupt byte.

## Interface
- `UART_BITS_TRANSFERED`, 8: data bits per frame, sent LSB first; no parity; one stop bit.
- `INPUT_CLK`, 100000000: `clk` frequency in Hz.
- `UART_CLK`, 115200: baud rate.
- `OVERSAMPLE`, 16: sample ticks per bit; must be even and ≥4.
- `DIV`, `INPUT_CLK/(UART_CLK*OVERSAMPLE)`: `clk` cycles per tick (integer, 54 at defaults); ≥1.

Ports:
- `clk`  in  1: single clock.
- `rst`  in  1: reset, asynchronous, active-high.
- `rx`  in  1: serial line, idle high, asynchronous to `clk`.
- `rx_valid`  out  1: one-cycle pulse; `rx_result` holds a good byte.
- `rx_result`  out  `UART_BITS_TRANSFERED`: last good byte, held until the next `rx_valid`.
- `frame_err`  out  1: one-cycle pulse; the stop bit was sampled low.
- `busy`  out  1: high whenever the state is not IDLE.

## Operation
- `rx` passes through a 2-flop synchronizer. Both flops reset to 1. The synchronized signal is `rx_s`. Nothing else samples raw `rx`.
- Tick generator: the divider counts 0..DIV-1 and emits `tick` when it reaches DIV-1. It is forced to 0 on the IDLE→START transition, so the first tick comes DIV cycles after detection.
- `scnt` is a tick counter, 0..OVERSAMPLE-1. `bcnt` is a bit counter, 0..UART_BITS_TRANSFERED-1. `shreg` is the shift register.
- States:
  - IDLE: if `rx_s`==0, go to START and clear `scnt`. The cycle in which this happens is cycle D.
  - START: on each tick, increment `scnt`. At the tick where `scnt`==OVERSAMPLE/2-1, sample `rx_s`.
    - If 0, go to DATA and clear `scnt`/`bcnt`.
    - If 1 (glitch), go to IDLE with no output.
  - DATA: at the tick where `scnt`==OVERSAMPLE-1, shift `rx_s` into the MSB of `shreg` (right shift, so LSB-first data lands correctly), clear `scnt`, and increment `bcnt`. After the last bit, go to STOP.
  - STOP: at the tick where `scnt`==OVERSAMPLE-1, sample `rx_s`.
    - If 1: `rx_result`←`shreg`, pulse `rx_valid`, go to IDLE.
    - If 0: pulse `frame_err`, go to BREAK. `rx_result` is unchanged.
  - BREAK: stay until `rx_s`==1, then go to IDLE. This prevents a held-low line from being read as repeated 0x00 frames.
- `rx_valid` and `frame_err` are registered. They are never high together, and each is high for exactly one cycle per frame.
- Reset (any time, including mid-frame):
  - State returns to IDLE.
  - Counters and `shreg` clear to 0.
  - Synchronizer flops go to 1.
  - `rx_valid`=0, `frame_err`=0, `busy`=0, `rx_result`=0.
  - A partially received frame is discarded.

## Timing
- Detection latency: cycle D is 2–3 `clk` after the falling edge of `rx`, set by synchronizer and phase.
- Sample points, counted in ticks after D (tick k lands at D+k·DIV):
  - start bit: tick OVERSAMPLE/2 (8);
  - data bit i: tick OVERSAMPLE/2+OVERSAMPLE·(i+1);
  - stop bit: tick OVERSAMPLE/2+OVERSAMPLE·(UART_BITS_TRANSFERED+1) (152).
- At defaults the stop bit is sampled at D+8208 and `rx_valid`/`frame_err` is high during cycle D+8209.
- Return to IDLE happens in the same edge as the valid/err pulse. A new start edge can be accepted from D+8209 on, so back-to-back frames with one stop bit are received with no loss.
- No backpressure: the consumer must take `rx_result` within one frame time (≥8640 cycles at defaults). An unread byte is silently overwritten.
- `busy` rises at D+1 (registered from the state) and falls together with the `rx_valid` pulse.

## Test plan
- Reset state: assert `rst` asynchronously with `rx`=1 → all outputs 0 immediately, `busy`=0. Release → idle with no pulses for 20000 cycles.
- Single byte: drive 0xA5 at 115200 baud, 8N1 (868 clk/bit) → exactly one `rx_valid`, `rx_result`=0xA5, `frame_err`=0, pulse lands 8209 cycles after D (±0).
- Start glitch: pull `rx` low for 200 clk, then high → `busy` pulses, returns to IDLE; no `rx_valid`, no `frame_err`. A following byte 0x3C is then received correctly.
- Framing error: send 0x55 with the stop bit driven 0, then hold `rx` low for 3 frame times, then high → one `frame_err` pulse, no `rx_valid`, `rx_result` keeps its prior value. The next byte 0x81 yields `rx_valid` with `rx_result`=0x81.
- Back-to-back: send 0x00, 0xFF, 0x7E with no idle gap → three `rx_valid` pulses with the values in order, none dropped.
- Mid-frame reset: assert `rst` during data bit 4 of 0xC3, release, then send 0x96 → no output for 0xC3; `rx_valid` with `rx_result`=0x96.

Source files
------------

// File: rtl/uart_rx_sampler.sv
// Oversampling 8N1 UART receiver: 2-flop synchronizer, tick divider, framing FSM.
// Latency: rx_valid/frame_err pulse OVERSAMPLE/2+OVERSAMPLE*(BITS+1) ticks + 1 clk after start detection.
// Backpressure: none; rx_result is overwritten by the next good frame, consumer must keep up.
//
// Ports:
//   clk        - single clock
//   rst        - asynchronous active-high reset
//   rx         - serial line, idle high, asynchronous to clk
//   rx_valid   - one-cycle pulse, rx_result holds a freshly received good byte
//   rx_result  - last good byte, held until the next rx_valid
//   frame_err  - one-cycle pulse, stop bit sampled low
//   busy       - high whenever the receiver is not idle
module uart_rx_sampler #(
  parameter int UART_BITS_TRANSFERED = 8,
  parameter int INPUT_CLK            = 100000000,
  parameter int UART_CLK             = 115200,
  parameter int OVERSAMPLE           = 16,
  parameter int DIV                  = INPUT_CLK / (UART_CLK * OVERSAMPLE)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            rx,
  output logic                            rx_valid,
  output logic [UART_BITS_TRANSFERED-1:0] rx_result,
  output logic                            frame_err,
  output logic                            busy
);

  localparam int NB   = UART_BITS_TRANSFERED;
  localparam int DIVW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW   = $clog2(OVERSAMPLE);
  localparam int BW   = (NB > 1) ? $clog2(NB) : 1;

  localparam logic [DIVW-1:0] DIV_LAST  = DIVW'(DIV - 1);
  localparam logic [SW-1:0]   SCNT_HALF = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0]   SCNT_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0]   BCNT_LAST = BW'(NB - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  state_t          state_q, state_d;
  logic            rx_m, rx_s;
  logic [DIVW-1:0] div_cnt;
  logic            tick;
  logic [SW-1:0]   scnt_q, scnt_d;
  logic [BW-1:0]   bcnt_q, bcnt_d;
  logic [NB-1:0]   shreg_q, shreg_d;
  logic [NB:0]     shift_in;
  logic [NB-1:0]   result_d;
  logic            valid_d, ferr_d, busy_d;

  // Synchronizer resets to the idle line level so reset never looks like a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  // Divider is held at 0 while idle, so counting starts fresh on the cycle
  // after start detection and the first tick lands exactly DIV cycles later.
  assign tick = (div_cnt == DIV_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (state_q == IDLE || tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIVW'(1);
    end
  end

  // Right shift: LSB-first data ends up in bit 0 after the last bit.
  assign shift_in = {rx_s, shreg_q};

  always_comb begin
    state_d  = state_q;
    scnt_d   = scnt_q;
    bcnt_d   = bcnt_q;
    shreg_d  = shreg_q;
    result_d = rx_result;
    valid_d  = 1'b0;
    ferr_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          scnt_d  = '0;
        end
      end

      START: begin
        if (tick) begin
          if (scnt_q == SCNT_HALF) begin
            // Mid start bit: still low means a real start, otherwise a glitch.
            if (!rx_s) begin
              state_d = DATA;
              scnt_d  = '0;
              bcnt_d  = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            scnt_d = scnt_q + SW'(1);
          end
        end
      end

      DATA: begin
        if (tick) begin
          if (scnt_q == SCNT_LAST) begin
            shreg_d = shift_in[NB:1];
            scnt_d  = '0;
            bcnt_d  = bcnt_q + BW'(1);
            if (bcnt_q == BCNT_LAST) begin
              state_d = STOP;
              bcnt_d  = '0;
            end
          end else begin
            scnt_d = scnt_q + SW'(1);
          end
        end
      end

      STOP: begin
        if (tick) begin
          if (scnt_q == SCNT_LAST) begin
            scnt_d = '0;
            if (rx_s) begin
              result_d = shreg_q;
              valid_d  = 1'b1;
              state_d  = IDLE;
            end else begin
              ferr_d  = 1'b1;
              state_d = BREAK;
            end
          end else begin
            scnt_d = scnt_q + SW'(1);
          end
        end
      end

      BREAK: begin
        // Wait for the line to recover so a held-low line is not re-read as frames.
        if (rx_s) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      scnt_q    <= '0;
      bcnt_q    <= '0;
      shreg_q   <= '0;
      rx_result <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      scnt_q    <= scnt_d;
      bcnt_q    <= bcnt_d;
      shreg_q   <= shreg_d;
      rx_result <= result_d;
      rx_valid  <= valid_d;
      frame_err <= ferr_d;
      busy      <= busy_d;
    end
  end

endmodule
